komandara_axi4lite_regfile: RTL and testbench
=============================================

KOMANDARA_AXI4LITE_REGFILE -- requirements
Module: komandara_axi4lite_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 32-bit registers, power of two, 2..256.
REQ-002 SHALL have parameter PRIV_ONLY, default 1'b0: when 1, only privileged (AxPROT[0]=1) accesses are honoured.
REQ-003 SHALL have parameter logic [NUM_REGS*32-1:0] RESET_VAL, default all zeros: per-register reset values.
REQ-004 SHALL have ports clk_i (input, 1, clock) and rst_i (input, 1, reset); one clock; reset is synchronous and active-high.
REQ-005 SHALL have AW channel ports s_awvalid_i (in, 1), s_awready_o (out, 1), s_awaddr_i (in, 32) and s_awprot_i (in, 3, axi_prot_e).
REQ-006 SHALL have W channel ports s_wvalid_i (in, 1), s_wready_o (out, 1), s_wdata_i (in, 32) and s_wstrb_i (in, 4).
REQ-007 SHALL have B channel ports s_bvalid_o (out, 1), s_bready_i (in, 1) and s_bresp_o (out, 2, axi_resp_e).
REQ-008 SHALL have AR channel ports s_arvalid_i (in, 1), s_arready_o (out, 1), s_araddr_i (in, 32) and s_arprot_i (in, 3).
REQ-009 SHALL have R channel ports s_rvalid_o (out, 1), s_rready_i (in, 1), s_rdata_o (out, 32) and s_rresp_o (out, 2).
REQ-010 SHALL have port regs_o (out, NUM_REGS*32): live register contents, register k in bits [32k+31:32k].
REQ-011 SHALL have port wr_pulse_o (out, NUM_REGS): one-cycle pulse on bit k when register k is written.

Function
REQ-012 Address decode SHALL be: addr[1:0]!=0 -> SLVERR; addr >= NUM_REGS*4 -> DECERR; PRIV_ONLY=1 and prot[0]=0 -> SLVERR; otherwise OKAY with index addr[$clog2(NUM_REGS)+1:2].
REQ-013 AW and W SHALL each have a one-entry holding register; awready = !aw_held and wready = !w_held; either may arrive first or both in the same cycle.
REQ-014 Write FSM SHALL have states W_IDLE and W_RESP; in W_IDLE with both held, it SHALL commit in that cycle, clear both holds and enter W_RESP.
REQ-015 A commit SHALL update only the bytes whose strobe bit is set, and only when the response is OKAY.
REQ-016 A commit SHALL pulse wr_pulse_o[index] on the next cycle only when the response is OKAY, including when wstrb=0.
REQ-017 In W_RESP, bvalid=1 with the registered bresp; on bvalid&&bready the FSM SHALL return to W_IDLE, and a new commit SHALL be allowed no earlier than the following cycle.
REQ-018 While in W_RESP, holds MAY fill (at most one AW and one W), and awready/wready SHALL then deassert until the next commit.
REQ-019 Read FSM SHALL have states R_IDLE and R_RESP; arready=1 only in R_IDLE; on AR handshake it SHALL capture rdata/rresp and enter R_RESP, giving one-cycle latency.
REQ-020 rdata SHALL be 32'h0 for any non-OKAY read.
REQ-021 In R_RESP, rvalid=1 and rdata/rresp SHALL stay stable until rready; on rvalid&&rready the FSM SHALL return to R_IDLE.
REQ-022 Read and write paths SHALL be independent; if a read captures in the same cycle as a write commit to the same register, the read SHALL return the pre-write value.
REQ-023 bvalid and rvalid SHALL never depend combinationally on bready or rready.

Reset
REQ-024 While rst_i=1 at a clock edge, registers SHALL load RESET_VAL, both FSMs SHALL enter IDLE and both holds SHALL clear.
REQ-025 During reset, bvalid, rvalid and wr_pulse_o SHALL be 0, awready, wready and arready SHALL be 0, and bresp, rresp and rdata SHALL be 0.
REQ-026 Reset mid-transaction SHALL drop any pending response and any uncommitted AW/W without modifying registers.
REQ-027 On the first cycle after reset, awready, wready and arready SHALL be 1.

Structure
REQ-028 axi_resp_e and axi_prot_e SHALL come from komandara_axi4lite_pkg; any new shared constant (e.g. AXI_DATA_W=32, AXI_STRB_W=4) SHALL be added there.
REQ-029 Address decode plus error classification SHALL be a reusable combinational function in komandara_axi4lite_pkg, shared by the read and write paths; no sub-module is required.

Verification
REQ-030 Write 0x0000_0008 data 0xDEADBEEF strb 0xF, then read 0x8 -> bresp OKAY, wr_pulse_o[2] for one cycle, rdata 0xDEADBEEF, rresp OKAY.
REQ-031 W sent 3 cycles before AW (addr 0x4, data 0x11223344, strb 0x5), reg1 initially 0 -> single commit, reg1 = 0x00220044.
REQ-032 Reads of 0x40 (NUM_REGS=16) and 0x6 -> DECERR then SLVERR, rdata 0, no register change; a write to 0x40 -> DECERR, no wr_pulse.
REQ-033 PRIV_ONLY=1, write to 0x0 with awprot 3'b000 -> SLVERR, reg0 unchanged; the same write with awprot 3'b001 -> OKAY.
REQ-034 bready held low 10 cycles while a second AW+W is presented -> second write held, not committed until the first B handshakes; bresp stable throughout.
REQ-035 rst_i asserted while bvalid=1 and rvalid=1 -> both drop the next cycle, all registers equal RESET_VAL, and readies return to 1 after release.

Source files
------------

// File: rtl/komandara_axi4lite_pkg.sv
// Shared AXI4-Lite types, widths and the register-window address decoder
// used by both the read and the write path of the register file.
package komandara_axi4lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    localparam int AXI_IDX_W  = 8;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    // Bit 0 privileged, bit 1 non-secure, bit 2 instruction.
    typedef enum logic [2:0] {
        AXI_PROT_UNPRIV    = 3'b000,
        AXI_PROT_PRIV      = 3'b001,
        AXI_PROT_NS        = 3'b010,
        AXI_PROT_NS_PRIV   = 3'b011,
        AXI_PROT_INSN      = 3'b100,
        AXI_PROT_INSN_PRIV = 3'b101,
        AXI_PROT_INSN_NS   = 3'b110,
        AXI_PROT_INSN_NS_P = 3'b111
    } axi_prot_e;

    typedef struct packed {
        axi_resp_e              resp;
        logic [AXI_IDX_W-1:0]   idx;
    } axi_dec_t;

    // Misalignment outranks out-of-window, which outranks the privilege check.
    function automatic axi_dec_t axi_decode(input logic [AXI_ADDR_W-1:0] addr,
                                            input logic [2:0]            prot,
                                            input logic                  priv_only,
                                            input int unsigned           num_regs);
        axi_dec_t d;
        d.idx = addr[AXI_IDX_W+1:2] & AXI_IDX_W'(num_regs - 1);
        if (addr[1:0] != 2'b00)
            d.resp = AXI_RESP_SLVERR;
        else if (addr >= AXI_ADDR_W'(num_regs * 4))
            d.resp = AXI_RESP_DECERR;
        else if (priv_only && !prot[0])
            d.resp = AXI_RESP_SLVERR;
        else
            d.resp = AXI_RESP_OKAY;
        return d;
    endfunction

endpackage

// File: rtl/komandara_axi4lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes,
// independent read/write paths and a per-register write pulse.
module komandara_axi4lite_regfile
    import komandara_axi4lite_pkg::*;
#(
    parameter int                     NUM_REGS  = 16,
    parameter logic                   PRIV_ONLY = 1'b0,
    parameter logic [NUM_REGS*32-1:0] RESET_VAL = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_awvalid_i,
    output logic                   s_awready_o,
    input  logic [31:0]            s_awaddr_i,
    input  logic [2:0]             s_awprot_i,
    input  logic                   s_wvalid_i,
    output logic                   s_wready_o,
    input  logic [31:0]            s_wdata_i,
    input  logic [3:0]             s_wstrb_i,
    output logic                   s_bvalid_o,
    input  logic                   s_bready_i,
    output logic [1:0]             s_bresp_o,
    input  logic                   s_arvalid_i,
    output logic                   s_arready_o,
    input  logic [31:0]            s_araddr_i,
    input  logic [2:0]             s_arprot_i,
    output logic                   s_rvalid_o,
    input  logic                   s_rready_i,
    output logic [31:0]            s_rdata_o,
    output logic [1:0]             s_rresp_o,
    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]    wr_pulse_o
);

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_RESP } r_state_e;

    logic                         aw_held_q, w_held_q;
    logic [31:0]                  aw_addr_q, w_data_q, rdata_q, rd_word;
    logic [2:0]                   aw_prot_q;
    logic [3:0]                   w_strb_q;
    w_state_e                     w_state_q;
    r_state_e                     r_state_q;
    axi_resp_e                    bresp_q, rresp_q;
    logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
    logic [NUM_REGS-1:0]          wr_pulse_q, wr_pulse_d;
    axi_dec_t                     wdec, rdec;
    logic                         commit, wr_ok, aw_rdy, w_rdy, ar_rdy;

    assign wdec   = axi_decode(aw_addr_q, aw_prot_q, PRIV_ONLY, NUM_REGS);
    assign rdec   = axi_decode(s_araddr_i, s_arprot_i, PRIV_ONLY, NUM_REGS);
    assign commit = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
    assign wr_ok  = commit && (wdec.resp == AXI_RESP_OKAY);
    assign aw_rdy = !aw_held_q && !rst_i;
    assign w_rdy  = !w_held_q && !rst_i;
    assign ar_rdy = (r_state_q == R_IDLE) && !rst_i;

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        rd_word    = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_ok && wdec.idx == AXI_IDX_W'(k)) begin
                wr_pulse_d[k] = 1'b1;
                for (int b = 0; b < AXI_STRB_W; b++)
                    if (w_strb_q[b]) regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
            end
            if (rdec.idx == AXI_IDX_W'(k)) rd_word = regs_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q     <= RESET_VAL;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Holds are only freed by a commit, so a capture and a clear never coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_state_q <= W_IDLE;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            if (s_awvalid_i && aw_rdy) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_awaddr_i;
                aw_prot_q <= s_awprot_i;
            end else if (commit) begin
                aw_held_q <= 1'b0;
            end
            if (s_wvalid_i && w_rdy) begin
                w_held_q <= 1'b1;
                w_data_q <= s_wdata_i;
                w_strb_q <= s_wstrb_i;
            end else if (commit) begin
                w_held_q <= 1'b0;
            end
            case (w_state_q)
                W_IDLE: if (commit) begin
                    bresp_q   <= wdec.resp;
                    w_state_q <= W_RESP;
                end
                W_RESP: if (s_bready_i) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs_q, so a same-cycle commit is not yet visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            rresp_q   <= AXI_RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (s_arvalid_i) begin
                    rresp_q   <= rdec.resp;
                    rdata_q   <= (rdec.resp == AXI_RESP_OKAY) ? rd_word : '0;
                    r_state_q <= R_RESP;
                end
                R_RESP: if (s_rready_i) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_awready_o = aw_rdy;
    assign s_wready_o  = w_rdy;
    assign s_arready_o = ar_rdy;
    assign s_bvalid_o  = (w_state_q == W_RESP) && !rst_i;
    assign s_bresp_o   = rst_i ? 2'b00 : bresp_q;
    assign s_rvalid_o  = (r_state_q == R_RESP) && !rst_i;
    assign s_rresp_o   = rst_i ? 2'b00 : rresp_q;
    assign s_rdata_o   = rst_i ? 32'h0 : rdata_q;
    assign wr_pulse_o  = rst_i ? '0 : wr_pulse_q;
    assign regs_o      = regs_q;

endmodule

// File: tb/tb_komandara_axi4lite_regfile.sv
// Scoreboard bench: expected B/R responses are queued as stimulus is issued
// and popped when the DUT answers; a shadow register model tracks contents.
module tb_komandara_axi4lite_regfile;

    localparam int N = 16;

    function automatic logic [N*32-1:0] mk_rv();
        logic [N*32-1:0] v;
        for (int k = 0; k < N; k++) v[k*32 +: 32] = (k == 1) ? 32'h0 : (32'hC0DE_0000 | k);
        return v;
    endfunction
    localparam logic [N*32-1:0] RV = mk_rv();

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0] awprot, arprot;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [N*32-1:0] regs;
    logic [N-1:0] wr_pulse;

    logic p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready, p_arready, p_rvalid;
    logic [31:0] p_awaddr, p_wdata, p_rdata;
    logic [2:0] p_awprot;
    logic [1:0] p_bresp, p_rresp;
    logic [N*32-1:0] p_regs;
    logic [N-1:0] p_wr_pulse;

    komandara_axi4lite_regfile #(.NUM_REGS(N), .PRIV_ONLY(1'b0), .RESET_VAL(RV)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_awvalid_i(awvalid), .s_awready_o(awready), .s_awaddr_i(awaddr), .s_awprot_i(awprot),
        .s_wvalid_i(wvalid), .s_wready_o(wready), .s_wdata_i(wdata), .s_wstrb_i(wstrb),
        .s_bvalid_o(bvalid), .s_bready_i(bready), .s_bresp_o(bresp),
        .s_arvalid_i(arvalid), .s_arready_o(arready), .s_araddr_i(araddr), .s_arprot_i(arprot),
        .s_rvalid_o(rvalid), .s_rready_i(rready), .s_rdata_o(rdata), .s_rresp_o(rresp),
        .regs_o(regs), .wr_pulse_o(wr_pulse)
    );

    komandara_axi4lite_regfile #(.NUM_REGS(N), .PRIV_ONLY(1'b1)) dut_p (
        .clk_i(clk), .rst_i(rst),
        .s_awvalid_i(p_awvalid), .s_awready_o(p_awready), .s_awaddr_i(p_awaddr), .s_awprot_i(p_awprot),
        .s_wvalid_i(p_wvalid), .s_wready_o(p_wready), .s_wdata_i(p_wdata), .s_wstrb_i(4'hF),
        .s_bvalid_o(p_bvalid), .s_bready_i(p_bready), .s_bresp_o(p_bresp),
        .s_arvalid_i(1'b0), .s_arready_o(p_arready), .s_araddr_i(32'h0), .s_arprot_i(3'b000),
        .s_rvalid_o(p_rvalid), .s_rready_i(1'b1), .s_rdata_o(p_rdata), .s_rresp_o(p_rresp),
        .regs_o(p_regs), .wr_pulse_o(p_wr_pulse)
    );

    typedef struct { logic [1:0] resp; logic [31:0] data; } exp_t;
    exp_t bq[$];
    exp_t rq[$];
    logic [31:0] model [N];
    int errors = 0, checks = 0;
    int pulse_cnt [N];

    initial for (int k = 0; k < N; k++) pulse_cnt[k] = 0;
    always @(posedge clk)
        for (int k = 0; k < N; k++) if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;

    function automatic int pulse_sum();
        int s = 0;
        for (int k = 0; k < N; k++) s += pulse_cnt[k];
        return s;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] p, input logic priv);
        if (a[1:0] != 2'b00) return 2'b10;
        if (a >= 32'(N*4)) return 2'b11;
        if (priv && !p[0]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic model_matches();
        for (int k = 0; k < N; k++) if (regs[k*32 +: 32] !== model[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) model[k] = RV[k*32 +: 32];
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        exp_t e;
        e.resp = exp_resp(a, p, 1'b0);
        e.data = 32'h0;
        bq.push_back(e);
        if (e.resp == 2'b00)
            for (int b = 0; b < 4; b++) if (s[b]) model[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic exp_read(input logic [31:0] a);
        exp_t e;
        e.resp = exp_resp(a, 3'b000, 1'b0);
        e.data = (e.resp == 2'b00) ? model[a[5:2]] : 32'h0;
        rq.push_back(e);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_aw(input logic [31:0] a, input logic [2:0] p);
        logic ok; int n;
        awaddr = a; awprot = p; awvalid = 1'b1; n = 0;
        do begin ok = awready; @(posedge clk); #1; n++; end while (!ok && n < 50);
        awvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL aw_handshake: awready never seen in %0d cycles", n); end
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        logic ok; int n;
        wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
        do begin ok = wready; @(posedge clk); #1; n++; end while (!ok && n < 50);
        wvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL w_handshake: wready never seen in %0d cycles", n); end
    endtask

    task automatic send_ar(input logic [31:0] a);
        logic ok; int n;
        araddr = a; arprot = 3'b000; arvalid = 1'b1; n = 0;
        do begin ok = arready; @(posedge clk); #1; n++; end while (!ok && n < 50);
        arvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_handshake: arready never seen in %0d cycles", n); end
    endtask

    task automatic wait_valid(input logic is_b);
        int n = 0;
        while (((is_b ? bvalid : rvalid) !== 1'b1) && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL wait_valid: %s never asserted", is_b ? "bvalid" : "rvalid"); end
    endtask

    task automatic collect_b(input string nm);
        exp_t e; logic [1:0] got; logic seen; int n;
        bready = 1'b1; seen = 1'b0; n = 0; got = 2'bxx;
        while (!seen && n < 50) begin
            if (bvalid === 1'b1) begin seen = 1'b1; got = bresp; end
            @(posedge clk); #1; n++;
        end
        bready = 1'b0;
        checks++;
        if (bq.size() == 0) begin errors++; $display("FAIL %s: B response with empty scoreboard", nm); end
        else begin
            e = bq.pop_front();
            if (!seen) begin errors++; $display("FAIL %s: bvalid timeout, required bresp %0d", nm, e.resp); end
            else if (got !== e.resp) begin errors++; $display("FAIL %s: bresp got %0d required %0d", nm, got, e.resp); end
        end
    endtask

    task automatic collect_r(input string nm);
        exp_t e; logic [1:0] gr; logic [31:0] gd; logic seen; int n;
        rready = 1'b1; seen = 1'b0; n = 0; gr = 2'bxx; gd = 'x;
        while (!seen && n < 50) begin
            if (rvalid === 1'b1) begin seen = 1'b1; gr = rresp; gd = rdata; end
            @(posedge clk); #1; n++;
        end
        rready = 1'b0;
        checks++;
        if (rq.size() == 0) begin errors++; $display("FAIL %s: R response with empty scoreboard", nm); end
        else begin
            e = rq.pop_front();
            if (!seen) begin errors++; $display("FAIL %s: rvalid timeout", nm); end
            else if (gr !== e.resp || gd !== e.data) begin
                errors++;
                $display("FAIL %s: rresp/rdata got %0d/%h required %0d/%h", nm, gr, gd, e.resp, e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || wr_pulse !== '0 ||
            {bresp, rresp} !== 4'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b pulse=%h resp=%0d/%0d rdata=%h, required all 0",
                     awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp, rdata);
        end
        checks++;
        if (regs !== RV) begin errors++; $display("FAIL reset_regs: regs %h required %h", regs, RV); end
        rst = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL reset_release_ready: got %b%b%b required 111", awready, wready, arready);
        end
    endtask

    task automatic test_basic();
        int p2, ps;
        p2 = pulse_cnt[2]; ps = pulse_sum();
        fork send_aw(32'h8, 3'b000); send_w(32'hDEADBEEF, 4'hF); join
        exp_write(32'h8, 32'hDEADBEEF, 4'hF, 3'b000);
        collect_b("basic_bresp");
        repeat (2) @(posedge clk); #1;
        checks++;
        if (pulse_cnt[2] !== p2 + 1 || pulse_sum() !== ps + 1) begin
            errors++; $display("FAIL basic_pulse: reg2 pulses %0d total %0d, required %0d/%0d",
                               pulse_cnt[2] - p2, pulse_sum() - ps, 1, 1);
        end
        exp_read(32'h8);
        send_ar(32'h8);
        collect_r("basic_read");
        checks++;
        if (regs[2*32 +: 32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_regs: reg2 %h required deadbeef", regs[2*32 +: 32]);
        end
    endtask

    task automatic test_w_first();
        int p1; logic bad;
        p1 = pulse_cnt[1]; bad = 1'b0;
        send_w(32'h11223344, 4'h5);
        repeat (3) begin
            if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL w_first_hold: early response or wrong readies, required bv=0 wr=0 awr=1"); end
        send_aw(32'h4, 3'b000);
        exp_write(32'h4, 32'h11223344, 4'h5, 3'b000);
        collect_b("w_first_bresp");
        checks++;
        if (regs[1*32 +: 32] !== 32'h00220044 || pulse_cnt[1] !== p1 + 1) begin
            errors++; $display("FAIL w_first_merge: reg1 %h pulses %0d required 00220044 / 1",
                               regs[1*32 +: 32], pulse_cnt[1] - p1);
        end
    endtask

    task automatic test_errors();
        logic [N*32-1:0] snap; int ps, p3;
        snap = regs; ps = pulse_sum();
        exp_read(32'h40); send_ar(32'h40); collect_r("err_read_decerr");
        exp_read(32'h6);  send_ar(32'h6);  collect_r("err_read_slverr");
        fork send_aw(32'h40, 3'b000); send_w(32'hFFFFFFFF, 4'hF); join
        exp_write(32'h40, 32'hFFFFFFFF, 4'hF, 3'b000);
        collect_b("err_write_decerr");
        fork send_aw(32'h2, 3'b000); send_w(32'hFFFFFFFF, 4'hF); join
        exp_write(32'h2, 32'hFFFFFFFF, 4'hF, 3'b000);
        collect_b("err_write_slverr");
        @(posedge clk); #1;
        checks++;
        if (regs !== snap || pulse_sum() !== ps) begin
            errors++; $display("FAIL err_side_effect: %0d pulses, regs changed=%b, required 0 / 0",
                               pulse_sum() - ps, regs !== snap);
        end
        p3 = pulse_cnt[3];
        fork send_aw(32'hC, 3'b000); send_w(32'hFFFFFFFF, 4'h0); join
        exp_write(32'hC, 32'hFFFFFFFF, 4'h0, 3'b000);
        collect_b("strb0_bresp");
        @(posedge clk); #1;
        checks++;
        if (pulse_cnt[3] !== p3 + 1 || regs !== snap) begin
            errors++; $display("FAIL strb0: reg3 pulses %0d regs changed=%b, required 1 / 0",
                               pulse_cnt[3] - p3, regs !== snap);
        end
    endtask

    task automatic test_back_to_back();
        int p5; logic bad;
        bready = 1'b0;
        fork send_aw(32'h10, 3'b000); send_w(32'h0000_0001, 4'hF); join
        exp_write(32'h10, 32'h1, 4'hF, 3'b000);
        wait_valid(1'b1);
        p5 = pulse_cnt[5]; bad = 1'b0;
        fork send_aw(32'h14, 3'b000); send_w(32'h0000_0002, 4'hF); join
        exp_write(32'h14, 32'h2, 4'hF, 3'b000);
        repeat (10) begin
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0 ||
                pulse_cnt[5] !== p5) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL b2b_stall: response/readies/commit changed while bready low"); end
        collect_b("b2b_first");
        collect_b("b2b_second");
        @(posedge clk); #1;
        checks++;
        if (pulse_cnt[5] !== p5 + 1 || !model_matches()) begin
            errors++; $display("FAIL b2b_commit: reg5 pulses %0d model match %b, required 1 / 1",
                               pulse_cnt[5] - p5, model_matches());
        end
    endtask

    // AW/W hold at one edge, commit lands on the next edge together with the AR capture.
    task automatic test_rd_wr_collide();
        fork send_aw(32'h18, 3'b000); send_w(32'h5555AAAA, 4'hF); join
        exp_read(32'h18);
        send_ar(32'h18);
        exp_write(32'h18, 32'h5555AAAA, 4'hF, 3'b000);
        collect_r("collide_old_value");
        collect_b("collide_bresp");
    endtask

    task automatic test_sweep();
        logic [31:0] d; logic [3:0] s;
        for (int k = 0; k < N; k++) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            fork send_aw(32'(k*4), 3'b010); send_w(d, s); join
            exp_write(32'(k*4), d, s, 3'b010);
            collect_b("sweep_bresp");
        end
        for (int k = 0; k < N; k++) begin
            exp_read(32'(k*4)); send_ar(32'(k*4)); collect_r("sweep_read");
        end
        checks++;
        if (!model_matches()) begin errors++; $display("FAIL sweep_regs: regs %h differ from model", regs); end
    endtask

    task automatic p_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] p,
                           output logic [1:0] r, output logic ok);
        int n = 0;
        p_awaddr = a; p_wdata = d; p_awprot = p; p_awvalid = 1'b1; p_wvalid = 1'b1; p_bready = 1'b1;
        while (!(p_awready && p_wready) && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        p_awvalid = 1'b0; p_wvalid = 1'b0;
        while (p_bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        r = p_bresp; ok = (n < 50);
        @(posedge clk); #1;
    endtask

    task automatic test_priv();
        logic [1:0] r; logic ok;
        p_write(32'h0, 32'hA5A5A5A5, 3'b000, r, ok);
        checks++;
        if (!ok || r !== exp_resp(32'h0, 3'b000, 1'b1) || p_regs[31:0] !== 32'h0) begin
            errors++; $display("FAIL priv_unpriv: ok=%b bresp %0d reg0 %h, required SLVERR(2) / 00000000", ok, r, p_regs[31:0]);
        end
        p_write(32'h0, 32'hA5A5A5A5, 3'b001, r, ok);
        checks++;
        if (!ok || r !== exp_resp(32'h0, 3'b001, 1'b1) || p_regs[31:0] !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL priv_priv: ok=%b bresp %0d reg0 %h, required OKAY(0) / a5a5a5a5", ok, r, p_regs[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        int ps; logic bad;
        bready = 1'b0; rready = 1'b0;
        fork send_aw(32'h20, 3'b000); send_w(32'hCAFEF00D, 4'hF); join
        exp_write(32'h20, 32'hCAFEF00D, 4'hF, 3'b000);
        wait_valid(1'b1);
        exp_read(32'h8); send_ar(32'h8);
        wait_valid(1'b0);
        send_aw(32'h24, 3'b000);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || {awready, wready, arready} !== 3'b000 || regs !== RV) begin
            errors++; $display("FAIL rst_mid: bv=%b rv=%b rdy=%b%b%b regs_ok=%b, required 0 0 000 1",
                               bvalid, rvalid, awready, wready, arready, regs === RV);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL rst_mid_ready: got %b%b%b required 111", awready, wready, arready);
        end
        bq.delete(); rq.delete(); model_reset();
        @(posedge clk); #1;
        ps = pulse_sum(); bad = 1'b0;
        send_w(32'h12345678, 4'hF);
        repeat (4) begin
            if (bvalid !== 1'b0 || pulse_sum() !== ps) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rst_drop_aw: a write committed from an AW dropped by reset"); end
        send_aw(32'h24, 3'b000);
        exp_write(32'h24, 32'h12345678, 4'hF, 3'b000);
        collect_b("rst_after_write");
        checks++;
        if (!model_matches()) begin errors++; $display("FAIL rst_after_regs: regs %h differ from model", regs); end
    endtask

    initial begin
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; awprot = 0; wdata = 0; wstrb = 0; araddr = 0; arprot = 0;
        p_awvalid = 0; p_wvalid = 0; p_bready = 1; p_awaddr = 0; p_wdata = 0; p_awprot = 0;
        model_reset();
        test_reset();
        test_basic();
        test_w_first();
        test_errors();
        test_back_to_back();
        test_rd_wr_collide();
        test_sweep();
        test_priv();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
